// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives COUNT, COUNT big-endian words and an XOR
// checksum over a byte handshake, writes words from address 0 and releases CpuHold on success.
module imem_loader #(
    parameter int unsigned IM = 5,
    parameter int unsigned N  = 32
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [7:0]    ByteIn,
    input  logic          ByteValid,
    output logic          ByteReady,
    output logic          WrEn,
    output logic [IM-1:0] WrAddr,
    output logic [N-1:0]  WrData,
    output logic          CpuHold,
    output logic          Done,
    output logic          Error
);

    localparam int unsigned CW    = IM + 1;
    localparam int unsigned DEPTH = 2 ** IM;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_wcnt;
    logic [1:0]    r_bidx;
    logic [23:0]   r_asm;
    logic [7:0]    r_acc;
    logic          r_ready;
    logic          r_wren;
    logic [IM-1:0] r_wraddr;
    logic [N-1:0]  r_wrdata;
    logic          r_hold;
    logic          r_done;
    logic          r_err;

    logic          w_xfer;
    logic          w_bad_count;
    logic          w_last_word;

    assign w_xfer      = ByteValid & r_ready;
    assign w_bad_count = (ByteIn == 8'd0) || (32'(ByteIn) > DEPTH);
    assign w_last_word = (r_wcnt == (r_count - CW'(1)));

    // Single-process FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_wcnt   <= '0;
            r_bidx   <= '0;
            r_asm    <= '0;
            r_acc    <= '0;
            r_ready  <= 1'b1;
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_wrdata <= '0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_bad_count) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_count <= CW'(ByteIn);
                            r_wcnt  <= '0;
                            r_bidx  <= '0;
                            r_acc   <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_asm <= {r_asm[15:0], ByteIn};
                        r_acc <= r_acc ^ ByteIn;
                        if (r_bidx == 2'd3) begin
                            r_wrdata <= N'({r_asm, ByteIn});
                            r_wraddr <= r_wcnt[IM-1:0];
                            r_wren   <= 1'b1;
                            r_wcnt   <= r_wcnt + CW'(1);
                            r_bidx   <= '0;
                            if (w_last_word) begin
                                r_state <= S_CHECK;
                            end
                        end else begin
                            r_bidx <= r_bidx + 2'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (ByteIn == r_acc) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_ERR;
                    r_ready <= 1'b0;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign ByteReady = r_ready;
    assign WrEn      = r_wren;
    assign WrAddr    = r_wraddr;
    assign WrData    = r_wrdata;
    assign CpuHold   = r_hold;
    assign Done      = r_done;
    assign Error     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write log captured on the falling edge, outputs checked
// one delta after each rising edge.
module tb_imem_loader;

    localparam int unsigned IM = 5;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic [7:0]    ByteIn = 8'h00;
    logic          ByteValid = 1'b0;
    logic          ByteReady;
    logic          WrEn;
    logic [IM-1:0] WrAddr;
    logic [31:0]   WrData;
    logic          CpuHold;
    logic          Done;
    logic          Error;

    int n_cmp = 0;
    int n_bad = 0;
    int n_b2b = 0;
    logic prev_wren = 1'b0;

    logic [IM-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    logic [31:0]   pay[32];

    imem_loader #(.IM(IM), .N(32)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 clk = ~clk;

    // Write log plus detection of back-to-back strobes.
    always @(negedge clk) begin
        if (WrEn) begin
            wa_q.push_back(WrAddr);
            wd_q.push_back(WrData);
        end
        if (WrEn && prev_wren) n_b2b++;
        prev_wren = WrEn;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        ByteIn    = b;
        ByteValid = 1'b1;
        @(posedge clk);
        #1;
        ByteValid = 1'b0;
    endtask

    task automatic send_payload(input int cnt, input int maxgap, output logic [7:0] chk);
        logic [31:0] w;
        chk = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            w = pay[i];
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
                chk = chk ^ w[k*8 +: 8];
            end
        end
    endtask

    task automatic do_reset();
        #1;
        Reset     = 1'b1;
        ByteValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ByteReady), 32'd1);
        check({tag, "_wren"},  32'(WrEn),      32'd0);
        check({tag, "_addr"},  32'(WrAddr),    32'd0);
        check({tag, "_data"},  WrData,         32'd0);
        check({tag, "_hold"},  32'(CpuHold),   32'd1);
        check({tag, "_done"},  32'(Done),      32'd0);
        check({tag, "_err"},   32'(Error),     32'd0);
    endtask

    initial begin
        logic [7:0] chk;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        check_reset_outputs("rst");

        // Two-word load at full rate; final data byte and CHK back to back
        do_reset();
        pay[0] = 32'h20080005;
        pay[1] = 32'h012A5020;
        send_byte(8'h02, 0);
        send_payload(2, 0, chk);
        check("two_chkval", 32'(chk), 32'h76);
        check("two_last_wren", 32'(WrEn), 32'd1);
        check("two_last_addr", 32'(WrAddr), 32'd1);
        check("two_done_pre", 32'(Done), 32'd0);
        send_byte(8'h76, 0);
        check("two_wren_off", 32'(WrEn), 32'd0);
        check("two_done", 32'(Done), 32'd1);
        check("two_hold", 32'(CpuHold), 32'd0);
        check("two_ready", 32'(ByteReady), 32'd0);
        check("two_err", 32'(Error), 32'd0);
        check("two_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("two_a0", 32'(wa_q[0]), 32'd0);
            check("two_d0", wd_q[0], 32'h20080005);
            check("two_a1", 32'(wa_q[1]), 32'd1);
            check("two_d1", wd_q[1], 32'h012A5020);
        end
        repeat (3) @(posedge clk);
        #1;
        check("two_done_sticky", 32'(Done), 32'd1);

        // Bad checksum: writes happen, then sticky error and extra bytes ignored
        do_reset();
        send_byte(8'h02, 0);
        send_payload(2, 0, chk);
        send_byte(8'h77, 0);
        check("bad_err", 32'(Error), 32'd1);
        check("bad_hold", 32'(CpuHold), 32'd1);
        check("bad_ready", 32'(ByteReady), 32'd0);
        check("bad_done", 32'(Done), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 1);
        send_byte(8'h55, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check("bad_nwr", 32'(wa_q.size()), 32'd2);
        check("bad_err_sticky", 32'(Error), 32'd1);
        check("bad_hold_sticky", 32'(CpuHold), 32'd1);

        // Illegal counts 0 and 33
        do_reset();
        send_byte(8'h00, 0);
        check("cnt0_err", 32'(Error), 32'd1);
        check("cnt0_ready", 32'(ByteReady), 32'd0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        check("cnt0_nwr", 32'(wa_q.size()), 32'd0);
        do_reset();
        send_byte(8'h21, 0);
        check("cnt33_err", 32'(Error), 32'd1);
        check("cnt33_hold", 32'(CpuHold), 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        check("cnt33_nwr", 32'(wa_q.size()), 32'd0);

        // Full depth (32 words) with random gaps between bytes
        do_reset();
        for (int i = 0; i < 32; i++) pay[i] = $urandom;
        send_byte(8'h20, 2);
        send_payload(32, 3, chk);
        send_byte(chk, 2);
        check("full_done", 32'(Done), 32'd1);
        check("full_err", 32'(Error), 32'd0);
        check("full_nwr", 32'(wa_q.size()), 32'd32);
        if (wa_q.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                check($sformatf("full_a%0d", i), 32'(wa_q[i]), 32'(i));
                check($sformatf("full_d%0d", i), wd_q[i], pay[i]);
            end
        end

        // Reset mid-load, with a byte presented during reset
        do_reset();
        pay[0] = 32'hDEADBEEF;
        pay[1] = 32'h01234567;
        send_byte(8'h02, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 1);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        send_byte(8'h01, 0);
        send_byte(8'h23, 2);
        check("mid_nwr", 32'(wa_q.size()), 32'd1);
        Reset     = 1'b1;
        ByteIn    = 8'h02;
        ByteValid = 1'b1;
        @(posedge clk);
        #1;
        ByteValid = 1'b0;
        Reset     = 1'b0;
        check_reset_outputs("mid");
        wa_q.delete();
        wd_q.delete();
        pay[0] = 32'hCAFEF00D;
        pay[1] = 32'h13579BDF;
        send_byte(8'h02, 1);
        send_payload(2, 1, chk);
        send_byte(chk, 0);
        check("mid_done", 32'(Done), 32'd1);
        check("mid_hold", 32'(CpuHold), 32'd0);
        check("mid_nwr2", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("mid_a0", 32'(wa_q[0]), 32'd0);
            check("mid_d0", wd_q[0], 32'hCAFEF00D);
            check("mid_a1", 32'(wa_q[1]), 32'd1);
            check("mid_d1", wd_q[1], 32'h13579BDF);
        end

        check("no_b2b_wren", 32'(n_b2b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
